// File: rtl/draw_engine.sv
// Rasterising draw engine: turns decoded LD/RD/DISP commands into a pixel
// stream (valid/ready) for the framebuffer writer; done reports idle.
module draw_engine #(
  parameter int XW = 9,
  parameter int YW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [2:0]    ctrl_ALU,
  input  logic [XW-1:0] x1,
  input  logic [YW-1:0] y1,
  input  logic [XW-1:0] x2,
  input  logic [YW-1:0] y2,
  output logic [XW-1:0] px_x,
  output logic [YW-1:0] px_y,
  output logic          px_valid,
  input  logic          px_ready,
  output logic          disp_req,
  output logic          done
);

  localparam logic [2:0] OP_LD   = 3'b100;
  localparam logic [2:0] OP_RD   = 3'b101;
  localparam logic [2:0] OP_DISP = 3'b111;

  typedef enum logic [1:0] {IDLE, LINE, RECT, FIN} state_t;
  state_t state;

  // Shared end-point registers: line end (x2,y2) or rectangle far corner (xh,yh)
  logic [XW-1:0] end_x, x_lo;
  logic [YW-1:0] end_y;
  logic          sx_neg, sy_neg;
  logic signed [XW+1:0] dx, dy, err;

  // Accept-time setup terms
  logic [XW-1:0] adx, xl, xh;
  logic [YW-1:0] ady, yl, yh;
  logic signed [XW+1:0] dx0, dy0;

  always_comb begin
    adx = (x2 >= x1) ? x2 - x1 : x1 - x2;
    ady = (y2 >= y1) ? y2 - y1 : y1 - y2;
    dx0 = {2'b00, adx};
    dy0 = -$signed({{(XW+2-YW){1'b0}}, ady});
    xl  = (x1 < x2) ? x1 : x2;
    xh  = (x1 < x2) ? x2 : x1;
    yl  = (y1 < y2) ? y1 : y2;
    yh  = (y1 < y2) ? y2 : y1;
  end

  // Bresenham step decision from the current error term
  logic signed [XW+2:0] e2, dx_e, dy_e;
  logic signed [XW+1:0] err_nxt;
  logic                 step_x, step_y;

  always_comb begin
    e2      = {err, 1'b0};
    dx_e    = {dx[XW+1], dx};
    dy_e    = {dy[XW+1], dy};
    step_x  = (e2 >= dy_e);
    step_y  = (e2 <= dx_e);
    err_nxt = err;
    if (step_x) err_nxt = err_nxt + dy;
    if (step_y) err_nxt = err_nxt + dx;
  end

  logic at_end;
  assign at_end = (px_x == end_x) && (px_y == end_y);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= IDLE;
      done     <= 1'b1;
      px_valid <= 1'b0;
      px_x     <= '0;
      px_y     <= '0;
      disp_req <= 1'b0;
      end_x    <= '0;
      end_y    <= '0;
      x_lo     <= '0;
      sx_neg   <= 1'b0;
      sy_neg   <= 1'b0;
      dx       <= '0;
      dy       <= '0;
      err      <= '0;
    end else begin
      disp_req <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            done <= 1'b0;
            case (ctrl_ALU)
              OP_LD: begin
                state    <= LINE;
                px_valid <= 1'b1;
                px_x     <= x1;
                px_y     <= y1;
                end_x    <= x2;
                end_y    <= y2;
                dx       <= dx0;
                dy       <= dy0;
                err      <= dx0 + dy0;
                sx_neg   <= !(x1 < x2);
                sy_neg   <= !(y1 < y2);
              end
              OP_RD: begin
                state    <= RECT;
                px_valid <= 1'b1;
                px_x     <= xl;
                px_y     <= yl;
                x_lo     <= xl;
                end_x    <= xh;
                end_y    <= yh;
              end
              OP_DISP: begin
                state    <= FIN;
                disp_req <= 1'b1;
              end
              default: state <= FIN;
            endcase
          end
        end
        LINE: begin
          if (px_ready) begin
            if (at_end) begin
              state    <= FIN;
              px_valid <= 1'b0;
            end else begin
              if (step_x) px_x <= sx_neg ? px_x - 1'b1 : px_x + 1'b1;
              if (step_y) px_y <= sy_neg ? px_y - 1'b1 : px_y + 1'b1;
              err <= err_nxt;
            end
          end
        end
        RECT: begin
          if (px_ready) begin
            if (at_end) begin
              state    <= FIN;
              px_valid <= 1'b0;
            end else if (px_x == end_x) begin
              px_x <= x_lo;
              px_y <= px_y + 1'b1;
            end else begin
              px_x <= px_x + 1'b1;
            end
          end
        end
        FIN: begin
          state <= IDLE;
          done  <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/draw_engine.md
Name: draw_engine

Overview:
- Downstream consumer of the instruction decoder: takes the decoded ctrl_ALU opcode and coordinate pair (x1,y1)-(x2,y2) and rasterises them into a stream of pixel writes toward the framebuffer writer.
- Supports three opcodes: LD is a Bresenham line, RD is a filled axis-aligned rectangle, DISP is a display-flip request.
- Drives done, which feeds the decoder's done_in, so the decoder issues a new command only when this engine is idle.

Parameters:
- XW, 9, x coordinate width (0..511)
- YW, 8, y coordinate width (0..255)

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-low reset (0 = reset)
- start  in  1  command strobe; sampled only while idle
- ctrl_ALU  in  3  opcode: 100 LD, 101 RD, 110 CD, 111 DISP
- x1  in  9  start x
- y1  in  8  start y
- x2  in  9  end x
- y2  in  8  end y
- px_x  out  9  pixel x
- px_y  out  8  pixel y
- px_valid  out  1  pixel valid
- px_ready  in  1  downstream accepts pixel
- disp_req  out  1  one-cycle display-flip pulse
- done  out  1  1 = idle, ready for a command

Behaviour:
- Reset (reset=0 at clk edge): state IDLE, done=1, px_valid=0, px_x=0, px_y=0, disp_req=0, all internal registers cleared. Reset overrides everything and aborts any command mid-draw; no further pixels are emitted.
- States: IDLE, LINE, RECT, FIN.
- IDLE, done=1: on start=1, latch ctrl_ALU/x1/y1/x2/y2, drop done to 0 the next cycle, and branch on opcode:
  - LD: go to LINE.
  - RD: go to RECT.
  - DISP: disp_req=1 for exactly one cycle, then FIN.
  - CD and any other opcode: unsupported, emit no pixels, go to FIN.
- Latching: all inputs are registered at accept. Input changes during a command are ignored. start while done=0 is ignored.
- Pixel handshake:
  - The pixel transfers on a cycle where px_valid=1 and px_ready=1.
  - px_x/px_y are held stable while px_valid=1 and px_ready=0.
  - The next pixel appears in the cycle after a transfer, giving 1 pixel/cycle when px_ready is held at 1.
- LINE:
  - Init: dx=|x2-x1|, dy=-|y2-y1|, sx=+1 if x1<x2 else -1, sy=+1 if y1<y2 else -1, err=dx+dy.
  - err is signed 11 bits; e2=2*err is signed 12 bits. No overflow is possible at these widths.
  - First pixel is (x1,y1), px_valid=1 in the cycle after accept.
  - On each transfer: if (x,y)==(x2,y2), go to FIN. Otherwise compute e2 from the current err, then:
    - if e2>=dy: err+=dy, x+=sx
    - if e2<=dx: err+=dx, y+=sy
    - both updates may occur in the same step.
  - Endpoint inclusive. Pixel count = max(|dx|,|dy|)+1.
- RECT:
  - Corners normalised: xl=min(x1,x2), xh=max(x1,x2), yl=min(y1,y2), yh=max(y1,y2).
  - Raster order: x increments from xl to xh, then x wraps to xl and y increments, ending at (xh,yh).
  - Pixel count = (xh-xl+1)*(yh-yl+1). First pixel is (xl,yl) in the cycle after accept.
- FIN: px_valid=0 for one cycle, then IDLE with done=1. done rises exactly 2 cycles after the last pixel transfer, or 2 cycles after accept for DISP/CD.
- Coordinate counters never wrap: all arithmetic stays within 0..511 / 0..255 because the endpoints bound it.
- Simultaneous reset and start: reset wins.

Test Plan:
- LD (0,0)-(3,1), px_ready=1 -> pixels (0,0),(1,0),(2,1),(3,1) on 4 consecutive cycles starting 1 cycle after start; done=1 two cycles after the last one.
- LD (3,2)-(0,2), then LD (5,5)-(5,5) -> first: (3,2),(2,2),(1,2),(0,2); second: exactly one pixel (5,5).
- RD (10,20)-(8,21) -> (8,20),(9,20),(10,20),(8,21),(9,21),(10,21), then done.
- LD (0,0)-(4,4) with px_ready toggling 1,0,0,1,... -> pixels (0,0)..(4,4) in order, none dropped or duplicated, coordinates stable while stalled.
- LD (511,255)-(0,0) -> 512 pixels, first (511,255), last (0,0), x decrements by 1 on every pixel.
- DISP -> disp_req high one cycle, no px_valid. CD -> no pixels and done returns. start pulsed mid-line -> ignored. reset=0 mid-RECT -> next cycle px_valid=0, done=1; the following start works normally.
